// File: rtl/csrxchg_pkg.sv
// Shared constants, decode types and the fixed program image for the
// CSR-exchange micro-core.
package csrxchg_pkg;

    localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
    localparam int          ROM_WORDS = 16;

    // Opcode match patterns, each compared against the top bits of the word
    localparam logic [16:0] OP_ADD_W   = 17'b00000000000100000;
    localparam logic [9:0]  OP_ADDI_W  = 10'b0000001010;
    localparam logic [9:0]  OP_ORI     = 10'b0000001110;
    localparam logic [6:0]  OP_LU12I_W = 7'b0001010;
    localparam logic [7:0]  OP_CSR     = 8'b00000100;
    localparam logic [5:0]  OP_B       = 6'b010100;

    // CSR numbers
    localparam logic [13:0] CSR_CRMD  = 14'h000;
    localparam logic [13:0] CSR_PRMD  = 14'h001;
    localparam logic [13:0] CSR_ECFG  = 14'h004;
    localparam logic [13:0] CSR_ERA   = 14'h006;
    localparam logic [13:0] CSR_SAVE0 = 14'h030;
    localparam logic [13:0] CSR_SAVE1 = 14'h031;
    localparam logic [13:0] CSR_SAVE2 = 14'h032;
    localparam logic [13:0] CSR_SAVE3 = 14'h033;

    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

    typedef enum logic [3:0] {
        I_NOP,
        I_ADD,
        I_ADDI,
        I_ORI,
        I_LU12I,
        I_CSRRD,
        I_CSRWR,
        I_CSRXCHG,
        I_BR
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [13:0] csr;
        logic [31:0] imm;
    } dec_t;

    // Fixed program: build SAVE0 = 0x53, exchange low nibble with 0x6, read back
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        logic [31:0] w;
        case (idx)
            32'd0:   w = 32'h0281_4C06;  // addi.w  r6,r0,0x53
            32'd1:   w = 32'h0400_C026;  // csrwr   r6,0x30
            32'd2:   w = 32'h0280_1808;  // addi.w  r8,r0,0x06
            32'd3:   w = 32'h0280_3C07;  // addi.w  r7,r0,0x0f
            32'd4:   w = 32'h0400_C0E8;  // csrxchg r8,r7,0x30
            32'd5:   w = 32'h0400_C008;  // csrrd   r8,0x30
            32'd6:   w = 32'h0281_6805;  // addi.w  r5,r0,0x5a
            32'd7:   w = 32'h5000_0000;  // b       0
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Anything that matches no pattern decodes to I_NOP
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.op  = I_NOP;
        d.rd  = ins[4:0];
        d.rj  = ins[9:5];
        d.rk  = ins[14:10];
        d.csr = ins[23:10];
        d.imm = '0;
        if (ins[31:15] == OP_ADD_W) begin
            d.op = I_ADD;
        end else if (ins[31:22] == OP_ADDI_W) begin
            d.op  = I_ADDI;
            d.imm = {{20{ins[21]}}, ins[21:10]};
        end else if (ins[31:22] == OP_ORI) begin
            d.op  = I_ORI;
            d.imm = {20'b0, ins[21:10]};
        end else if (ins[31:25] == OP_LU12I_W) begin
            d.op  = I_LU12I;
            d.imm = {ins[24:5], 12'b0};
        end else if (ins[31:24] == OP_CSR) begin
            if (ins[9:5] == 5'd0)      d.op = I_CSRRD;
            else if (ins[9:5] == 5'd1) d.op = I_CSRWR;
            else                       d.op = I_CSRXCHG;
        end else if (ins[31:26] == OP_B) begin
            d.op  = I_BR;
            d.imm = {{4{ins[9]}}, ins[9:0], ins[25:10], 2'b00};
        end
        return d;
    endfunction

endpackage

// File: rtl/csrxchg_top_csr_file.sv
// Small CSR file: combinational read, bit-masked write, fixed writable masks.
module csr_file
    import csrxchg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [31:0] wmask_i,
    input  logic [31:0] wdata_i
);

    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [31:0] era_q, era_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] wval;

    // Read mux; unimplemented numbers and read-only bits return zero
    always_comb begin
        rdata_o = '0;
        case (csr_num_i)
            CSR_CRMD:  rdata_o = {23'b0, crmd_q};
            CSR_PRMD:  rdata_o = {29'b0, prmd_q};
            CSR_ECFG:  rdata_o = {19'b0, ecfg_q};
            CSR_ERA:   rdata_o = era_q;
            CSR_SAVE0: rdata_o = save_q[0];
            CSR_SAVE1: rdata_o = save_q[1];
            CSR_SAVE2: rdata_o = save_q[2];
            CSR_SAVE3: rdata_o = save_q[3];
            default:   rdata_o = '0;
        endcase
    end

    // Merge write data into the addressed CSR's current value under wmask
    always_comb begin
        wval   = (rdata_o & ~wmask_i) | (wdata_i & wmask_i);
        crmd_d = crmd_q;
        prmd_d = prmd_q;
        ecfg_d = ecfg_q;
        era_d  = era_q;
        save_d = save_q;
        if (we_i) begin
            case (csr_num_i)
                CSR_CRMD:  crmd_d    = wval[8:0];
                CSR_PRMD:  prmd_d    = wval[2:0];
                CSR_ECFG:  ecfg_d    = wval[12:0];
                CSR_ERA:   era_d     = wval;
                CSR_SAVE0: save_d[0] = wval;
                CSR_SAVE1: save_d[1] = wval;
                CSR_SAVE2: save_d[2] = wval;
                CSR_SAVE3: save_d[3] = wval;
                default:   ;
            endcase
        end
    end

    // CSR state; reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q <= CRMD_RESET[8:0];
            prmd_q <= '0;
            ecfg_q <= '0;
            era_q  <= '0;
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
        end else begin
            crmd_q <= crmd_d;
            prmd_q <= prmd_d;
            ecfg_q <= ecfg_d;
            era_q  <= era_d;
            save_q <= save_d;
        end
    end

endmodule

// File: rtl/csrxchg_top.sv
// Single-cycle LoongArch32 subset core running a fixed ROM program that
// exercises CSRRD / CSRWR / CSRXCHG, with a registered write-back trace.
module csrxchg_top #(
    parameter logic [31:0] RESET_PC  = csrxchg_pkg::RESET_PC,
    parameter int          ROM_WORDS = csrxchg_pkg::ROM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    output logic        debug_wb_valid,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    import csrxchg_pkg::*;

    localparam int IDX_W = $clog2(ROM_WORDS);

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        gpr_q [32];
    logic [31:0]        ins;
    dec_t               dec;
    logic [4:0]         rkd_addr;
    logic [31:0]        rj_val, rkd_val;
    logic [31:0]        csr_rdata;
    logic               gpr_we;
    logic [31:0]        gpr_wdata;
    logic               csr_we;
    logic [31:0]        csr_wmask, csr_wdata;
    logic [IDX_W+1:0]   pc_low_d;
    logic               rf_wen;

    // Fetch, decode and GPR read; r0 is hard-wired to zero
    always_comb begin
        ins      = rom_word(32'(pc_q[IDX_W+1:2]));
        dec      = decode(ins);
        rkd_addr = (dec.op == I_ADD) ? dec.rk : dec.rd;
        rj_val   = (dec.rj == 5'd0)   ? 32'd0 : gpr_q[dec.rj];
        rkd_val  = (rkd_addr == 5'd0) ? 32'd0 : gpr_q[rkd_addr];
    end

    csr_file u_csr (
        .clk       (clk),
        .reset     (reset),
        .csr_num_i (dec.csr),
        .rdata_o   (csr_rdata),
        .we_i      (csr_we),
        .wmask_i   (csr_wmask),
        .wdata_i   (csr_wdata)
    );

    // Execute: GPR result, CSR write request and next pc
    always_comb begin
        gpr_we    = 1'b0;
        gpr_wdata = '0;
        csr_we    = 1'b0;
        csr_wmask = '0;
        csr_wdata = '0;
        pc_low_d  = pc_q[IDX_W+1:0] + (IDX_W+2)'(4);
        case (dec.op)
            I_ADD: begin
                gpr_we    = 1'b1;
                gpr_wdata = rj_val + rkd_val;
            end
            I_ADDI: begin
                gpr_we    = 1'b1;
                gpr_wdata = rj_val + dec.imm;
            end
            I_ORI: begin
                gpr_we    = 1'b1;
                gpr_wdata = rj_val | dec.imm;
            end
            I_LU12I: begin
                gpr_we    = 1'b1;
                gpr_wdata = dec.imm;
            end
            I_CSRRD: begin
                gpr_we    = 1'b1;
                gpr_wdata = csr_rdata;
            end
            I_CSRWR: begin
                gpr_we    = 1'b1;
                gpr_wdata = csr_rdata;
                csr_we    = 1'b1;
                csr_wmask = '1;
                csr_wdata = rkd_val;
            end
            I_CSRXCHG: begin
                gpr_we    = 1'b1;
                gpr_wdata = csr_rdata;
                csr_we    = 1'b1;
                csr_wmask = rj_val;
                csr_wdata = rkd_val;
            end
            I_BR: begin
                pc_low_d = pc_q[IDX_W+1:0] + dec.imm[IDX_W+1:0];
            end
            default: ;
        endcase
        // Only the ROM index moves; the pc region above it stays fixed
        pc_d   = {pc_q[31:IDX_W+2], pc_low_d};
        rf_wen = gpr_we && (dec.rd != 5'd0);
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    // General-purpose register file; reset aborts any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (rf_wen) begin
            gpr_q[dec.rd] <= gpr_wdata;
        end
    end

    // Write-back trace of the instruction committed at this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            debug_wb_valid    <= 1'b0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= 1'b0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_valid    <= 1'b1;
            debug_wb_pc       <= pc_q;
            debug_wb_rf_wen   <= rf_wen;
            debug_wb_rf_wnum  <= rf_wen ? dec.rd : 5'd0;
            debug_wb_rf_wdata <= rf_wen ? gpr_wdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_csrxchg_top.sv
// Scoreboard bench for csrxchg_top: expected retirements are queued by the
// stimulus process and consumed by a negedge monitor.
module tb_csrxchg_top;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        debug_wb_valid;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        bit          chk_save;
        logic [31:0] save;
        bit          chk_rf;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    csrxchg_top dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_valid    (debug_wb_valid),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic wen, input logic [4:0] wnum,
                        input logic [31:0] wdata, input bit chk_save, input logic [31:0] save,
                        input bit chk_rf);
        exp_t x;
        x.pc = pc; x.wen = wen; x.wnum = wnum; x.wdata = wdata;
        x.chk_save = chk_save; x.save = save; x.chk_rf = chk_rf;
        sb_q.push_back(x);
    endtask

    // Monitor: every visible retirement must match the head of the scoreboard
    always @(negedge clk) begin
        if (debug_wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got pc %h expected none", debug_wb_pc);
            end else begin
                e = sb_q.pop_front();
                chk("wb_pc", debug_wb_pc, e.pc);
                chk("wb_wen", 32'(debug_wb_rf_wen), 32'(e.wen));
                chk("wb_wnum", 32'(debug_wb_rf_wnum), 32'(e.wnum));
                chk("wb_wdata", debug_wb_rf_wdata, e.wdata);
                if (e.chk_save) chk("save0", dut.u_csr.save_q[0], e.save);
                if (e.chk_rf) begin
                    chk("rf_r5", dut.gpr_q[5], 32'h5a);
                    chk("rf_r8", dut.gpr_q[8], 32'h56);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hold reset three cycles; the trace must stay quiet
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_valid", 32'(debug_wb_valid), 32'd0);
            chk("reset_pc", debug_wb_pc, 32'd0);
        end

        push(32'h1c00_0000, 1'b1, 5'd6, 32'h53, 1'b0, 32'h0,  1'b0);
        push(32'h1c00_0004, 1'b1, 5'd6, 32'h00, 1'b1, 32'h53, 1'b0);
        push(32'h1c00_0008, 1'b1, 5'd8, 32'h06, 1'b0, 32'h0,  1'b0);
        push(32'h1c00_000c, 1'b1, 5'd7, 32'h0f, 1'b0, 32'h0,  1'b0);
        push(32'h1c00_0010, 1'b1, 5'd8, 32'h53, 1'b1, 32'h56, 1'b0);
        push(32'h1c00_0014, 1'b1, 5'd8, 32'h56, 1'b1, 32'h56, 1'b0);
        push(32'h1c00_0018, 1'b1, 5'd5, 32'h5a, 1'b0, 32'h0,  1'b1);
        for (int i = 0; i < 5; i++)
            push(32'h1c00_001c, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);

        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;

        // Mid-program reset: trace clears, CSRs and GPRs return to reset values
        @(posedge clk); #1;
        chk("midreset_valid", 32'(debug_wb_valid), 32'd0);
        chk("midreset_pc", debug_wb_pc, 32'd0);
        push(32'h1c00_0000, 1'b1, 5'd6, 32'h53, 1'b0, 32'h0,  1'b0);
        push(32'h1c00_0004, 1'b1, 5'd6, 32'h00, 1'b1, 32'h53, 1'b0);
        push(32'h1c00_0008, 1'b1, 5'd8, 32'h06, 1'b0, 32'h0,  1'b0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_retire: got %0d outstanding expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
